ov5640_dvp_tx: RTL and testbench

- Synthesizable OV5640 DVP source emulator: converts a 16-bit RGB565 pixel stream into 8-bit camera-style output with vsync, href and data, two bytes per pixel, high byte first.
- Drives the ov5640_data capture path on-chip for loopback/bring-up without a sensor.
- Also serves as the stimulus source for capture benches.
- Runs on one clock; each sys_clk cycle is one DVP pclk cycle.

---
 rtl/ov5640_pkg.sv | 21 ++
 rtl/ov5640_timing_gen.sv | 94 +++++++++
 rtl/ov5640_dvp_tx.sv | 75 +++++++
 tb/tb_ov5640_dvp_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 DVP emulator and the ov5640_data capture path:
// frame state encoding and default 640x480 timing.
package ov5640_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    localparam int DEF_H_VALID = 640;
    localparam int DEF_H_TOTAL = 784;
    localparam int DEF_V_SYNC  = 4;
    localparam int DEF_V_BACK  = 18;
    localparam int DEF_V_VALID = 480;
    localparam int DEF_V_FRONT = 8;
    localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_VALID + DEF_V_FRONT;

endpackage

// File: rtl/ov5640_timing_gen.sv
// Frame/line counters and frame state machine for the DVP emulator; one count per byte cycle.
// Produces the registered vsync/href/sof flags plus the combinational href window and byte phase.
module ov5640_timing_gen
    import ov5640_pkg::*;
#(
    parameter int H_VALID = DEF_H_VALID,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_VALID = DEF_V_VALID,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic enable_i,
    output logic win_o,
    output logic even_o,
    output logic sof_o,
    output logic vsync_o,
    output logic href_o
);

    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW = $clog2(2 * H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(2 * H_TOTAL - 1);
    localparam logic [HW-1:0] H_HREF_LAST = HW'(2 * H_VALID - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BACK_0    = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACTIVE_0  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_FRONT_0   = VW'(V_SYNC + V_BACK + V_VALID);

    state_e        state_q;
    logic [HW-1:0] cnt_h_q, cnt_h_d;
    logic [VW-1:0] cnt_v_q, cnt_v_d;
    logic          line_end, frame_end, win;
    logic          sof_q, vsync_q, href_q;

    always_comb begin
        line_end  = (cnt_h_q == H_LAST);
        frame_end = line_end && (cnt_v_q == V_LAST);
        cnt_h_d   = line_end ? '0 : cnt_h_q + 1'b1;
        cnt_v_d   = line_end ? cnt_v_q + 1'b1 : cnt_v_q;
        win       = (state_q == ACTIVE) && (cnt_h_q <= H_HREF_LAST);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            cnt_h_q <= '0;
            cnt_v_q <= '0;
            sof_q   <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            // Flags are registered from the current count, so they trail it by one cycle.
            sof_q   <= (state_q == VSYNC) && (cnt_v_q == '0) && (cnt_h_q == '0);
            vsync_q <= (state_q == VSYNC);
            href_q  <= win;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= VSYNC;
                        cnt_h_q <= '0;
                        cnt_v_q <= '0;
                    end
                end
                default: begin
                    if (frame_end) begin
                        state_q <= enable_i ? VSYNC : IDLE;
                        cnt_h_q <= '0;
                        cnt_v_q <= '0;
                    end else begin
                        cnt_h_q <= cnt_h_d;
                        cnt_v_q <= cnt_v_d;
                        if (line_end) begin
                            if (cnt_v_d == V_BACK_0)        state_q <= VBACK;
                            else if (cnt_v_d == V_ACTIVE_0) state_q <= ACTIVE;
                            else if (cnt_v_d == V_FRONT_0)  state_q <= VFRONT;
                        end
                    end
                end
            endcase
        end
    end

    assign win_o   = win;
    assign even_o  = ~cnt_h_q[0];
    assign sof_o   = sof_q;
    assign vsync_o = vsync_q;
    assign href_o  = href_q;

endmodule

// File: rtl/ov5640_dvp_tx.sv
// OV5640 DVP source emulator: serialises RGB565 pixels into high/low bytes under
// camera-style vsync/href timing, flagging any pixel the source failed to supply.
module ov5640_dvp_tx
    import ov5640_pkg::*;
#(
    parameter int H_VALID = DEF_H_VALID,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_VALID = DEF_V_VALID,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sof,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        underrun
);

    logic       win, even;
    logic [7:0] data_q, lo_q;
    logic       underrun_q;

    ov5640_timing_gen #(
        .H_VALID (H_VALID),
        .H_TOTAL (H_TOTAL),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_VALID (V_VALID),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .sys_clk_i (sys_clk),
        .sys_rst_i (sys_rst),
        .enable_i  (enable),
        .win_o     (win),
        .even_o    (even),
        .sof_o     (sof),
        .vsync_o   (dvp_vsync),
        .href_o    (dvp_href)
    );

    assign pix_ready = win & even;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_q     <= 8'h00;
            lo_q       <= 8'h00;
            underrun_q <= 1'b0;
        end else if (pix_ready) begin
            // A missing pixel still occupies its two byte slots, sent as zeros.
            if (pix_valid) begin
                data_q <= pix_data[15:8];
                lo_q   <= pix_data[7:0];
            end else begin
                data_q     <= 8'h00;
                lo_q       <= 8'h00;
                underrun_q <= 1'b1;
            end
        end else if (win) begin
            data_q <= lo_q;
        end else begin
            data_q <= 8'h00;
        end
    end

    assign dvp_data = data_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Randomised bench for ov5640_dvp_tx with small timing; a frame-position reference model
// predicts every output, and the byte stream is reassembled into pixels and compared.
module tb_ov5640_dvp_tx;

    localparam int HV = 4, HT = 6, VS = 1, VB = 1, VV = 2, VF = 1;
    localparam int HT2   = 2 * HT;
    localparam int FRAME = HT2 * (VS + VB + VV + VF);

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, sof, dvp_vsync, dvp_href, underrun;
    logic [7:0]  dvp_data;

    ov5640_dvp_tx #(
        .H_VALID (HV), .H_TOTAL (HT), .V_SYNC (VS),
        .V_BACK (VB), .V_VALID (VV), .V_FRONT (VF)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .sof       (sof),
        .dvp_vsync (dvp_vsync),
        .dvp_href  (dvp_href),
        .dvp_data  (dvp_data),
        .underrun  (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] pattern [8] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                                 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};

    // reference model: position within the frame, plus pending low byte and sticky error
    bit         m_ok = 0, m_run = 0, m_und = 0;
    int         m_pos = 0, m_fpix = 0;
    logic [7:0] m_lo = 8'h00;
    int         vmode = 0;
    bit         pat = 0;

    int          cyc = 0, last_sof = -1;
    int          sof_cnt, vs_cnt, hr_cnt, hs_cnt;
    bit          have_hi = 0;
    logic [7:0]  hi_b;
    logic [15:0] exp_q[$];
    logic [7:0]  blog[$];

    task automatic clr_stats();
        sof_cnt = 0; vs_cnt = 0; hr_cnt = 0; hs_cnt = 0;
        blog.delete();
    endtask

    task automatic step(input bit rst, input bit en);
        int line, col;
        bit vs_e, href_e, rdy_e, sof_e, pv;
        logic [7:0]  data_e;
        logic [15:0] pd;
        line   = m_pos / HT2;
        col    = m_pos % HT2;
        vs_e   = m_run && (line < VS);
        href_e = m_run && (line >= VS + VB) && (line < VS + VB + VV) && (col < 2 * HV);
        rdy_e  = href_e && (col % 2 == 0);
        sof_e  = m_run && (m_pos == 0);
        if (sof_e) m_fpix = 0;
        pd = pat ? pattern[m_fpix % 8] : 16'($urandom);
        case (vmode)
            0:       pv = 1'b1;
            1:       pv = ($urandom % 4) != 0;
            default: pv = !(rdy_e && m_fpix == 1);
        endcase
        sys_rst = rst; enable = en; pix_valid = pv; pix_data = pd;
        @(negedge sys_clk);
        if (m_ok) chk("pix_ready", pix_ready, rdy_e);
        if (pv && pix_ready) hs_cnt++;
        if (rst) begin
            vs_e = 0; href_e = 0; sof_e = 0; data_e = 8'h00;
            m_ok = 1; m_run = 0; m_pos = 0; m_und = 0; m_lo = 8'h00;
            exp_q.delete(); have_hi = 0; last_sof = -1;
        end else begin
            data_e = 8'h00;
            if (rdy_e) begin
                data_e = pv ? pd[15:8] : 8'h00;
                m_lo   = pv ? pd[7:0] : 8'h00;
                if (!pv) m_und = 1;
                exp_q.push_back(pv ? pd : 16'h0000);
                m_fpix++;
            end else if (href_e) begin
                data_e = m_lo;
            end
            if (m_run) begin
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    m_run = en;
                    if (!en) last_sof = -1;
                end else begin
                    m_pos++;
                end
            end else if (en) begin
                m_run = 1; m_pos = 0;
            end
        end
        @(posedge sys_clk);
        #1;
        if (m_ok) begin
            chk("vsync", dvp_vsync, vs_e);
            chk("href", dvp_href, href_e);
            chk("data", dvp_data, data_e);
            chk("sof", sof, sof_e);
            chk("underrun", underrun, m_und);
        end
        if (dvp_vsync) vs_cnt++;
        if (sof) begin
            sof_cnt++;
            if (last_sof >= 0) chk("frame_len", cyc - last_sof, FRAME);
            last_sof = cyc;
        end
        if (dvp_href) begin
            hr_cnt++;
            blog.push_back(dvp_data);
            if (!have_hi) begin
                hi_b = dvp_data; have_hi = 1;
            end else begin
                have_hi = 0;
                if (exp_q.size() == 0) chk("capture_extra", {hi_b, dvp_data}, 32'hFFFF_FFFF);
                else chk("capture", {hi_b, dvp_data}, exp_q.pop_front());
            end
        end
        cyc++;
    endtask

    logic [7:0] first4 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] under4 [4] = '{8'hA1, 8'hB2, 8'h00, 8'h00};

    initial begin
        int n;
        repeat (3) step(1, 0);

        // idle with enable low
        clr_stats();
        repeat (20) step(0, 0);
        chk("idle_sof_cnt", sof_cnt, 0);
        chk("idle_vsync_cnt", vs_cnt, 0);

        // one frame, always-valid patterned source, enable pulsed once
        pat = 1; vmode = 0;
        clr_stats();
        step(0, 1);
        repeat (FRAME + 15) step(0, 0);
        chk("f1_sof_cnt", sof_cnt, 1);
        chk("f1_vsync_len", vs_cnt, HT2 * VS);
        chk("f1_href_cnt", hr_cnt, 2 * HV * VV);
        chk("f1_handshakes", hs_cnt, HV * VV);
        chk("f1_byte_cnt", blog.size(), 2 * HV * VV);
        for (int i = 0; i < 4; i++)
            if (i < blog.size()) chk("f1_byte_seq", blog[i], first4[i]);

        // continuous frames with random pixels, enable dropped in VBACK of frame 3
        pat = 0;
        clr_stats();
        repeat (2 * FRAME + 15) step(0, 1);
        chk("cont_sof_cnt", sof_cnt, 3);
        clr_stats();
        repeat (FRAME + 20) step(0, 0);
        chk("drop_sof_cnt", sof_cnt, 0);
        chk("drop_href_cnt", hr_cnt, 2 * HV * VV);
        chk("drop_handshakes", hs_cnt, HV * VV);
        chk("drop_idle_vsync", dvp_vsync, 0);

        // missing second pixel of the first active line
        pat = 1; vmode = 2;
        clr_stats();
        repeat (FRAME + 5) step(0, 1);
        vmode = 0;
        repeat (FRAME + 10) step(0, 0);
        chk("und_sof_cnt", sof_cnt, 2);
        chk("und_sticky", underrun, 1);
        chk("und_href_cnt", hr_cnt, 2 * 2 * HV * VV);
        for (int i = 0; i < 4; i++)
            if (i < blog.size()) chk("und_byte_seq", blog[i], under4[i]);

        // random valid and random enable, after clearing the sticky flag
        step(1, 0);
        chk("rst_clears_underrun", underrun, 0);
        pat = 0; vmode = 1;
        repeat (6 * FRAME) step(0, ($urandom % 8) != 0);

        // reset in the middle of an active line, then restart
        step(1, 0);
        vmode = 0;
        n = 0;
        while (!(m_run && m_pos == HT2 * (VS + VB) + 6) && n < 4 * FRAME) begin
            step(0, 1);
            n++;
        end
        chk("reach_active", n < 4 * FRAME, 1);
        step(1, 1);
        chk("midrst_href", dvp_href, 0);
        chk("midrst_vsync", dvp_vsync, 0);
        chk("midrst_data", dvp_data, 8'h00);
        clr_stats();
        step(0, 1);
        repeat (5) step(0, 0);
        chk("restart_sof_cnt", sof_cnt, 1);
        repeat (FRAME) step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
